ctrl_mem_responder: RTL and testbench
=====================================

Name: ctrl_mem_responder

Overview:
Memory-side responder for the control unit's 512-bit line memory interface. It services the control unit's read and write requests against a local line store, one request at a time, with programmable latency. It also drives the buffer-address handshake that gates the control unit's start-up.
The block sits opposite the control unit's memory port and is used both in the accelerator shell and as the system-level bench memory.

Parameters:
DEPTH, 4096, number of 512-bit lines in the local store (power of two)
RD_LATENCY, 4, cycles from read acceptance to the data_valid pulse (>=1)
WR_LATENCY, 2, cycles from write acceptance to the write_done pulse (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_base_valid  input  1  single-cycle pulse; latches cfg_base_addr
cfg_base_addr  input  32  line address mapped to local index 0
bd_wr_en  input  1  backdoor write strobe for preload, ignored unless FSM is IDLE
bd_index  input  log2(DEPTH)  backdoor local line index
bd_data  input  512  backdoor line data
address  input  32  request line address from the control unit
read_request_valid  input  1  single-cycle read request pulse
write_request_valid  input  1  single-cycle write request pulse
write_data  input  512  write line, sampled with write_request_valid
buffer_addr_valid  output  1  level; high once a base address is latched
data_valid  output  1  single-cycle pulse; read_data is valid
read_data  output  512  read response line
write_done  output  1  single-cycle pulse; write committed
addr_err  output  1  sticky; an out-of-range request occurred
overrun  output  1  sticky; a request arrived while the FSM was busy
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous and active-low, drives to 0: buffer_addr_valid, data_valid, read_data, write_done, addr_err, overrun, base register and latency counter. FSM goes to IDLE.
- The line store is not cleared by reset.
- Reset asserted mid-operation aborts the request with no response. A write aborted before commit does not modify the store.
- cfg_base_valid latches the base and sets buffer_addr_valid on the next edge. It is accepted in any state and re-latching is allowed.
- Index computation: idx = address - base, as 32-bit unsigned. The request is in range iff idx < DEPTH.
- Requests arriving while buffer_addr_valid=0 are ignored, and no flags are set.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_DONE.
  - IDLE with write_request_valid: capture idx and write_data, load cnt=WR_LATENCY-1, go to WR_WAIT. If both request valids are high in the same cycle, the write wins and the read is dropped and sets overrun.
  - IDLE with read_request_valid: capture idx, load cnt=RD_LATENCY-1, go to RD_WAIT.
  - RD_WAIT: decrement cnt; at cnt==0 go to RD_RESP.
  - RD_RESP: read_data = store[idx] (all zeros if out of range, which also sets addr_err); data_valid=1 for exactly this cycle; return to IDLE.
  - WR_WAIT: decrement cnt; at cnt==0 go to WR_DONE.
  - WR_DONE: store[idx] = write_data if in range, otherwise the write is dropped and addr_err is set. write_done=1 for exactly this cycle; return to IDLE.
- Latency from the request pulse edge:
  - data_valid is high in cycle N+RD_LATENCY+1, where N is the request cycle.
  - write_done is high in cycle N+WR_LATENCY+1.
- A new request is acceptable in the cycle after the response pulse.
- read_data holds its value between responses.
- A request pulse received in any non-IDLE state (including the response cycle) is dropped and sets overrun.
- Backdoor writes in IDLE take effect on the next edge. A same-cycle IDLE request then reads the old contents.
- addr_err and overrun clear only on reset.

Test Plan:
- Reset, then cfg_base pulse with 0x1000 -> buffer_addr_valid rises on the next edge; all other outputs are 0.
- Backdoor store[5]=0xA5.. (512b); read address 0x1005 at cycle 10 with RD_LATENCY=4 -> data_valid is a single pulse at cycle 15 with read_data=0xA5..; busy is high in cycles 11-15.
- Write address 0x1007 with data 0x3C.., then a read of 0x1007 the cycle after write_done -> data 0x3C.. is returned; write_done arrives WR_LATENCY+1 cycles after the write request.
- Read address 0x0FFF and address 0x1000+DEPTH -> data_valid pulses with read_data=0 and addr_err=1; a write to 0x1000+DEPTH leaves the store unchanged.
- Simultaneous read and write pulse, plus a read pulse during RD_WAIT -> only the write is serviced; overrun=1; no extra data_valid.
- Assert rst_n low during WR_WAIT -> no write_done; the target line keeps its old data; buffer_addr_valid=0 until the base is reconfigured.

Source files
------------

// File: rtl/ctrl_mem_if.sv
// Control-unit <-> memory responder bus: base configuration, backdoor preload,
// line read/write requests and their responses and status flags.
interface ctrl_mem_if #(
    parameter int DEPTH = 4096
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             cfg_base_valid;
    logic [31:0]      cfg_base_addr;
    logic             bd_wr_en;
    logic [IDX_W-1:0] bd_index;
    logic [511:0]     bd_data;
    logic [31:0]      address;
    logic             read_request_valid;
    logic             write_request_valid;
    logic [511:0]     write_data;
    logic             buffer_addr_valid;
    logic             data_valid;
    logic [511:0]     read_data;
    logic             write_done;
    logic             addr_err;
    logic             overrun;
    logic             busy;

    modport slave (
        input  cfg_base_valid, cfg_base_addr, bd_wr_en, bd_index, bd_data,
        input  address, read_request_valid, write_request_valid, write_data,
        output buffer_addr_valid, data_valid, read_data, write_done,
        output addr_err, overrun, busy
    );

    modport master (
        output cfg_base_valid, cfg_base_addr, bd_wr_en, bd_index, bd_data,
        output address, read_request_valid, write_request_valid, write_data,
        input  buffer_addr_valid, data_valid, read_data, write_done,
        input  addr_err, overrun, busy
    );
endinterface

// File: rtl/ctrl_mem_responder.sv
// Single-outstanding 512-bit line memory responder with programmable read and
// write latency, base-relative addressing and sticky error/overrun flags.
module ctrl_mem_responder #(
    parameter int DEPTH      = 4096,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    ctrl_mem_if.slave mem
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_WAIT,
        S_WR_DONE
    } state_t;

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [31:0]       r_base;
    logic              r_base_valid;
    logic              r_addr_err;
    logic              r_overrun;
    logic [511:0]      r_read_data;

    logic [511:0]      r_store [DEPTH];
    logic [511:0]      r_mem_q;
    logic [IDX_W-1:0]  r_idx;
    logic              r_in_range;
    logic [511:0]      r_wdata;

    logic [31:0]       w_offset;
    logic              w_in_range;
    logic              w_idle;
    logic              w_accept_wr;
    logic              w_accept_rd;
    logic              w_overrun_set;
    logic              w_store_we;
    logic [IDX_W-1:0]  w_store_addr;
    logic [511:0]      w_store_din;
    logic [511:0]      w_resp_line;

    assign w_offset    = mem.address - r_base;
    assign w_in_range  = (w_offset < 32'(DEPTH));
    assign w_idle      = (r_state == S_IDLE);
    assign w_accept_wr = w_idle && r_base_valid && mem.write_request_valid;
    assign w_accept_rd = w_idle && r_base_valid && mem.read_request_valid
                         && !mem.write_request_valid;

    // A read colliding with a write in IDLE is dropped just like a busy-time request.
    assign w_overrun_set = r_base_valid &&
        ((!w_idle && (mem.read_request_valid || mem.write_request_valid)) ||
         (w_idle && mem.read_request_valid && mem.write_request_valid));

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept_wr) begin
                    w_state_next = S_WR_WAIT;
                    w_cnt_next   = WR_CNT_INIT;
                end else if (w_accept_rd) begin
                    w_state_next = S_RD_WAIT;
                    w_cnt_next   = RD_CNT_INIT;
                end
            end
            S_RD_WAIT: begin
                if (r_cnt == '0) w_state_next = S_RD_RESP;
                else             w_cnt_next   = r_cnt - CNT_W'(1);
            end
            S_RD_RESP: w_state_next = S_IDLE;
            S_WR_WAIT: begin
                if (r_cnt == '0) w_state_next = S_WR_DONE;
                else             w_cnt_next   = r_cnt - CNT_W'(1);
            end
            S_WR_DONE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_base_valid <= 1'b0;
            r_addr_err   <= 1'b0;
            r_overrun    <= 1'b0;
            r_read_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (mem.cfg_base_valid) begin
                r_base       <= mem.cfg_base_addr;
                r_base_valid <= 1'b1;
            end
            if (((r_state == S_RD_RESP) || (r_state == S_WR_DONE)) && !r_in_range)
                r_addr_err <= 1'b1;
            if (w_overrun_set)
                r_overrun <= 1'b1;
            if (r_state == S_RD_RESP)
                r_read_data <= w_resp_line;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept_wr || w_accept_rd) begin
            r_idx      <= w_offset[IDX_W-1:0];
            r_in_range <= w_in_range;
        end
        if (w_accept_wr)
            r_wdata <= mem.write_data;
    end

    // The store is only written in IDLE (backdoor) or WR_DONE, so a single port suffices.
    assign w_store_we   = (w_idle && mem.bd_wr_en) || ((r_state == S_WR_DONE) && r_in_range);
    assign w_store_addr = (r_state == S_WR_DONE) ? r_idx : mem.bd_index;
    assign w_store_din  = (r_state == S_WR_DONE) ? r_wdata : mem.bd_data;

    // Read-first on the accept edge: a same-cycle backdoor write is not observed.
    always_ff @(posedge clk) begin
        if (w_store_we)
            r_store[w_store_addr] <= w_store_din;
        if (w_accept_rd)
            r_mem_q <= r_store[w_offset[IDX_W-1:0]];
    end

    assign w_resp_line = r_in_range ? r_mem_q : '0;

    assign mem.buffer_addr_valid = r_base_valid;
    assign mem.data_valid        = (r_state == S_RD_RESP);
    assign mem.read_data         = (r_state == S_RD_RESP) ? w_resp_line : r_read_data;
    assign mem.write_done        = (r_state == S_WR_DONE);
    assign mem.addr_err          = r_addr_err;
    assign mem.overrun           = r_overrun;
    assign mem.busy              = !w_idle;
endmodule

// File: tb/tb_ctrl_mem_responder.sv
// Directed bench for ctrl_mem_responder: latency, addressing, error flags,
// overrun handling and reset abort, checked with immediate assertions.
module tb_ctrl_mem_responder;
    localparam int DEPTH      = 4096;
    localparam int RD_LATENCY = 4;
    localparam int WR_LATENCY = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   dv_count;

    logic [511:0] pat_a5, pat_3c, pat_11, pat_77, pat_ff, pat_ee;

    ctrl_mem_if #(.DEPTH(DEPTH)) mem ();

    ctrl_mem_responder #(
        .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY), .WR_LATENCY(WR_LATENCY)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem(mem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse a read now (cycle N); data_valid must appear only in cycle N+RD_LATENCY+1.
    task automatic do_read(input logic [31:0] addr, input logic [511:0] exp, input string tag);
        mem.address = addr;
        mem.read_request_valid = 1'b1;
        tick();
        mem.read_request_valid = 1'b0;
        for (int i = 1; i <= RD_LATENCY + 1; i++) begin
            if (i > 1) tick();
            chk({tag, "_dv"}, 512'(mem.data_valid), 512'(i == RD_LATENCY + 1));
            chk({tag, "_busy"}, 512'(mem.busy), 512'(1));
        end
        chk({tag, "_data"}, mem.read_data, exp);
        tick();
        chk({tag, "_dv_end"}, 512'(mem.data_valid), 512'(0));
        chk({tag, "_idle"}, 512'(mem.busy), 512'(0));
        chk({tag, "_hold"}, mem.read_data, exp);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [511:0] data, input string tag);
        mem.address = addr;
        mem.write_data = data;
        mem.write_request_valid = 1'b1;
        tick();
        mem.write_request_valid = 1'b0;
        for (int i = 1; i <= WR_LATENCY + 1; i++) begin
            if (i > 1) tick();
            chk({tag, "_wd"}, 512'(mem.write_done), 512'(i == WR_LATENCY + 1));
            chk({tag, "_busy"}, 512'(mem.busy), 512'(1));
        end
        tick();
        chk({tag, "_wd_end"}, 512'(mem.write_done), 512'(0));
        chk({tag, "_idle"}, 512'(mem.busy), 512'(0));
    endtask

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_3c = {64{8'h3C}};
        pat_11 = {64{8'h11}};
        pat_77 = {64{8'h77}};
        pat_ff = {64{8'hFF}};
        pat_ee = {64{8'hEE}};
        mem.cfg_base_valid = 1'b0;
        mem.cfg_base_addr = '0;
        mem.bd_wr_en = 1'b0;
        mem.bd_index = '0;
        mem.bd_data = '0;
        mem.address = '0;
        mem.read_request_valid = 1'b0;
        mem.write_request_valid = 1'b0;
        mem.write_data = '0;

        // Reset state
        tick(); tick();
        chk("rst_bav", 512'(mem.buffer_addr_valid), 512'(0));
        chk("rst_dv", 512'(mem.data_valid), 512'(0));
        chk("rst_rdata", mem.read_data, 512'(0));
        chk("rst_busy", 512'(mem.busy), 512'(0));
        rst_n = 1'b1;
        tick();

        // Base configuration
        mem.cfg_base_addr = 32'h1000;
        mem.cfg_base_valid = 1'b1;
        chk("cfg_bav_before", 512'(mem.buffer_addr_valid), 512'(0));
        tick();
        mem.cfg_base_valid = 1'b0;
        chk("cfg_bav", 512'(mem.buffer_addr_valid), 512'(1));
        chk("cfg_wd", 512'(mem.write_done), 512'(0));
        chk("cfg_aerr", 512'(mem.addr_err), 512'(0));
        chk("cfg_ovr", 512'(mem.overrun), 512'(0));
        chk("cfg_busy", 512'(mem.busy), 512'(0));

        // Backdoor preload of lines 5 and 0
        mem.bd_wr_en = 1'b1;
        mem.bd_index = 12'd5;
        mem.bd_data = pat_a5;
        tick();
        mem.bd_index = 12'd0;
        mem.bd_data = pat_11;
        tick();
        mem.bd_wr_en = 1'b0;

        do_read(32'h1005, pat_a5, "rd5");

        // Write then read back immediately after write_done
        do_write(32'h1007, pat_3c, "wr7");
        do_read(32'h1007, pat_3c, "rd7");

        // Out-of-range accesses
        chk("aerr_pre", 512'(mem.addr_err), 512'(0));
        do_read(32'h0FFF, 512'(0), "rd_low");
        chk("aerr_low", 512'(mem.addr_err), 512'(1));
        do_read(32'h1000 + DEPTH, 512'(0), "rd_high");
        do_write(32'h1000 + DEPTH, pat_ee, "wr_high");
        do_read(32'h1000, pat_11, "rd0_kept");
        chk("ovr_pre", 512'(mem.overrun), 512'(0));

        // Simultaneous read and write: write wins, read dropped
        mem.address = 32'h1009;
        mem.write_data = pat_77;
        mem.write_request_valid = 1'b1;
        mem.read_request_valid = 1'b1;
        tick();
        mem.write_request_valid = 1'b0;
        mem.read_request_valid = 1'b0;
        chk("sim_ovr", 512'(mem.overrun), 512'(1));
        chk("sim_busy", 512'(mem.busy), 512'(1));
        tick(); tick();
        chk("sim_wd", 512'(mem.write_done), 512'(1));
        chk("sim_dv", 512'(mem.data_valid), 512'(0));
        tick();
        do_read(32'h1009, pat_77, "rd9");

        // Second read pulse during RD_WAIT is dropped
        mem.address = 32'h1005;
        mem.read_request_valid = 1'b1;
        tick();
        mem.address = 32'h1009;
        tick();
        mem.read_request_valid = 1'b0;
        dv_count = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem.data_valid) begin
                dv_count++;
                chk("busyrd_data", mem.read_data, pat_a5);
            end
            tick();
        end
        chk("busyrd_dv_count", 512'(dv_count), 512'(1));
        chk("busyrd_ovr", 512'(mem.overrun), 512'(1));

        // Reset during WR_WAIT aborts the write
        mem.address = 32'h1005;
        mem.write_data = pat_ff;
        mem.write_request_valid = 1'b1;
        tick();
        mem.write_request_valid = 1'b0;
        chk("abort_busy_pre", 512'(mem.busy), 512'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_bav", 512'(mem.buffer_addr_valid), 512'(0));
        chk("abort_busy", 512'(mem.busy), 512'(0));
        chk("abort_ovr", 512'(mem.overrun), 512'(0));
        chk("abort_aerr", 512'(mem.addr_err), 512'(0));
        chk("abort_rdata", mem.read_data, 512'(0));
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_wd", 512'(mem.write_done), 512'(0));
        end

        // Requests ignored without a base
        mem.read_request_valid = 1'b1;
        tick();
        mem.read_request_valid = 1'b0;
        chk("nobase_busy", 512'(mem.busy), 512'(0));
        dv_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem.data_valid) dv_count++;
            tick();
        end
        chk("nobase_dv", 512'(dv_count), 512'(0));
        chk("nobase_ovr", 512'(mem.overrun), 512'(0));
        chk("nobase_bav", 512'(mem.buffer_addr_valid), 512'(0));

        // Reconfigure at a new base; line 5 still holds its pre-abort data
        mem.cfg_base_addr = 32'h2000;
        mem.cfg_base_valid = 1'b1;
        tick();
        mem.cfg_base_valid = 1'b0;
        chk("recfg_bav", 512'(mem.buffer_addr_valid), 512'(1));
        do_read(32'h2005, pat_a5, "rd5_kept");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
